mul_arbiter: RTL and testbench
==============================

Name: mul_arbiter

Overview:
- Shares one iterative 32-bit multiplier (start/done, multi-cycle) between N_REQ requesters, e.g. the integer pipeline and an address-generation or debug path.
- Round-robin arbitration; latches operands of the winner and holds the multiplier's start level until done.
- Returns the 32-bit low product to the winning requester as a one-cycle response pulse.
- Sits between the requesters and the multiplier, which is instantiated beside it, not inside it.

Parameters:
N_REQ, 2, number of requesters (2..8)
XLEN, 32, operand/result width
TIMEOUT, 40, max BUSY cycles before abort (used only with MUL_ARB_TIMEOUT_EN)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  N_REQ  per-requester request
req_a  in  N_REQ*XLEN  operand A, requester i at bits [i*XLEN +: XLEN]
req_b  in  N_REQ*XLEN  operand B, same packing
req_ready  out  N_REQ  one-hot accept; transfer when req_valid[i] & req_ready[i]
resp_valid  out  N_REQ  one-hot, one-cycle result pulse to the granted requester
resp_res  out  XLEN  product low word, valid with resp_valid
resp_err  out  1  timeout flag, valid with resp_valid; constant 0 without the macro
mul_a  out  XLEN  operand A to multiplier (latched)
mul_b  out  XLEN  operand B to multiplier (latched)
mul_start  out  1  level start; held high for the whole operation
mul_res  in  XLEN  multiplier result
mul_done  in  1  multiplier completion (may be combinational on mul_start)

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values:
  - state=IDLE, all outputs 0.
  - rr pointer = N_REQ-1, so requester 0 has first priority.
  - Operand and result registers cleared.
- IDLE:
  - req_ready is combinational: one-hot to the first valid requester searching from pointer+1 with wrap-around. 0 if none valid.
  - On a transfer: latch req_a/req_b of the winner, store the grant index, update the pointer to the winner, go to BUSY.
- BUSY:
  - mul_start=1; mul_a/mul_b driven from latched operands.
  - req_ready=0 for all requesters.
  - mul_done sampled at each clk edge. When 1: latch mul_res and go to RESP.
  - Minimum one BUSY cycle; zero operands may raise done in the first BUSY cycle.
- RESP:
  - resp_valid[grant]=1 and resp_res = latched result for exactly one cycle.
  - mul_start=0, which lets the multiplier drop its enable.
  - Next state is always IDLE. No backpressure on the response; requesters must accept it.
- Latency: accept at cycle 0, BUSY from cycle 1, done seen in cycle k, resp_valid in cycle k+1. Maximum back-to-back throughput is one op per (k+2) cycles.
- Fairness: a continuously valid requester is granted within N_REQ grants.
- Requester rules:
  - A requester must hold req_valid and its operands stable until ready.
  - Dropping req_valid before ready is allowed (request withdrawn).
  - A requester not granted keeps waiting.
- Simultaneous events: a new request during BUSY/RESP is not accepted. It is arbitrated in the next IDLE cycle against the pointer updated by the previous grant.
- Reset mid-operation: immediate return to IDLE, no resp_valid, mul_start low the next cycle. Latched data is discarded.
- Arithmetic: no computation in this block. resp_res = mul_res bits [XLEN-1:0], captured unmodified.

Optional Feature:
- Macro: MUL_ARB_TIMEOUT_EN.
- Enabled:
  - A BUSY cycle counter, width clog2(TIMEOUT+1), clears on entry to BUSY.
  - If the counter reaches TIMEOUT with mul_done still 0: go to RESP with resp_res=0 and resp_err=1, and drop mul_start.
  - mul_done and timeout in the same cycle: done wins, err=0.
- Disabled: no counter; BUSY waits indefinitely; resp_err tied to 0.

Decomposition:
- Package mul_arb_pkg: state enum {IDLE, BUSY, RESP}, XLEN default constant, and an onehot-to-index function.
- Sub-module rr_arbiter: purely combinational rotate-priority grant from req_valid and pointer. Parameterized N_REQ; outputs a one-hot grant plus the index.
- Pointer register and FSM stay in mul_arbiter.

Test Plan:
- Single op: req0 a=7, b=-3 with a model multiplier (done after 5 BUSY cycles) -> req_ready[0] in cycle 0; mul_start high cycles 1-5; resp_valid[0] in cycle 6 with resp_res=0xFFFFFFEB.
- Contention: req0 and req1 valid continuously after reset -> grants 0,1,0,1; each resp_valid goes only to its own index with the correct products (e.g. 3*4=12, 5*6=30).
- Zero operand: a=0, b=0x12345678 with done combinational on start -> exactly one BUSY cycle; resp_res=0 two cycles after accept.
- Reset in BUSY: rst asserted on the third BUSY cycle -> next cycle IDLE, mul_start=0, no resp_valid; the next request is granted to req0 first.
- Withdraw/late arrival: req1 valid during BUSY -> req_ready[1] only in the following IDLE. req0 drops valid before grant -> no operation started.
- MUL_ARB_TIMEOUT_EN with TIMEOUT=40 and mul_done stuck 0 -> resp_valid after 40 BUSY cycles with resp_err=1, resp_res=0. Also done on cycle 40 -> resp_err=0.

Source files
------------

// File: rtl/mul_arb_pkg.sv
// -----------------------------------------------------------------------------
// mul_arb_pkg
// Shared types and helpers for the multiplier arbiter slice.
//   state_e        : arbiter FSM states (IDLE, BUSY, RESP)
//   XLEN_DEF       : default operand/result width
//   onehot_to_idx  : converts a one-hot vector (up to 8 bits) to its bit index
// -----------------------------------------------------------------------------
package mul_arb_pkg;

    localparam int XLEN_DEF = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    // Returns the index of the set bit; 0 when no bit is set.
    function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/mul_arbiter_if.sv
// -----------------------------------------------------------------------------
// mul_arbiter_if
// Bundles the requester side and the multiplier side of the arbiter.
//   req_valid/req_a/req_b/req_ready : request channel, one lane per requester
//   resp_valid/resp_res/resp_err    : one-cycle response pulse, no backpressure
//   mul_a/mul_b/mul_start           : operands and level start to the multiplier
//   mul_res/mul_done                : multiplier result and completion
// Handshake: a request transfers on a clock edge where req_valid[i] and
// req_ready[i] are both high; a requester holds valid and operands stable until
// then, but may drop valid beforehand to withdraw. The response is a single
// cycle of resp_valid[i] that the requester must take.
// Modports: master = the arbiter, slave = the requesters plus the multiplier.
// -----------------------------------------------------------------------------
interface mul_arbiter_if #(
    parameter int N_REQ = 2,
    parameter int XLEN  = 32
);
    logic [N_REQ-1:0]      req_valid;
    logic [N_REQ*XLEN-1:0] req_a;
    logic [N_REQ*XLEN-1:0] req_b;
    logic [N_REQ-1:0]      req_ready;
    logic [N_REQ-1:0]      resp_valid;
    logic [XLEN-1:0]       resp_res;
    logic                  resp_err;
    logic [XLEN-1:0]       mul_a;
    logic [XLEN-1:0]       mul_b;
    logic                  mul_start;
    logic [XLEN-1:0]       mul_res;
    logic                  mul_done;

    modport master (
        input  req_valid, req_a, req_b, mul_res, mul_done,
        output req_ready, resp_valid, resp_res, resp_err, mul_a, mul_b, mul_start
    );

    modport slave (
        output req_valid, req_a, req_b, mul_res, mul_done,
        input  req_ready, resp_valid, resp_res, resp_err, mul_a, mul_b, mul_start
    );
endinterface

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational rotate-priority arbiter. The search starts at ptr_i+1
// and wraps around, so the last winner has the lowest priority.
//   req_i : per-requester request vector
//   ptr_i : index of the previous winner
//   gnt_o : one-hot grant (all zero when nothing requests)
//   idx_o : index of the granted requester (0 when nothing requests)
// -----------------------------------------------------------------------------
module rr_arbiter
    import mul_arb_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int IDXW  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDXW-1:0]  ptr_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [IDXW-1:0]  idx_o
);

    logic found;

    always_comb begin
        found = 1'b0;
        gnt_o = '0;
        // k is the distance from the pointer; the first valid lane at the
        // smallest distance wins.
        for (int k = 1; k <= N_REQ; k++) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (!found && req_i[i] && (i == ((int'(ptr_i) + k) % N_REQ))) begin
                    gnt_o[i] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
        idx_o = IDXW'(onehot_to_idx(8'(gnt_o)));
    end

endmodule

// File: rtl/mul_arbiter.sv
// -----------------------------------------------------------------------------
// mul_arbiter
// Shares one external iterative multiplier between N_REQ requesters with
// round-robin arbitration. The winner's operands are latched, mul_start is
// held high until mul_done, and the low product returns as a one-cycle
// resp_valid pulse to the winner.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : mul_arbiter_if master modport (requester and multiplier signals)
//   state_o  : current FSM state, for observation only
// Optional feature: define MUL_ARB_TIMEOUT_EN to abort an operation after
// TIMEOUT BUSY cycles without mul_done (response with resp_err=1, resp_res=0).
// -----------------------------------------------------------------------------
module mul_arbiter
    import mul_arb_pkg::*;
#(
    parameter int N_REQ   = 2,
    parameter int XLEN    = XLEN_DEF,
    parameter int TIMEOUT = 40
) (
    input  logic           clk,
    input  logic           rst,
    mul_arbiter_if.master  bus,
    output state_e         state_o
);

    localparam int IDXW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_e            state_q, state_d;
    logic [IDXW-1:0]   ptr_q, ptr_d;
    logic [IDXW-1:0]   grant_q, grant_d;
    logic [XLEN-1:0]   a_q, a_d;
    logic [XLEN-1:0]   b_q, b_d;
    logic [XLEN-1:0]   res_q, res_d;
    logic [N_REQ-1:0]  arb_gnt;
    logic [IDXW-1:0]   arb_idx;
    logic              accept;
    logic              done_now;
    logic              timeout_now;
    logic              resp_err_w;

    rr_arbiter #(.N_REQ(N_REQ), .IDXW(IDXW)) u_rr (
        .req_i (bus.req_valid),
        .ptr_i (ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx)
    );

    // The grant is one-hot on a valid lane, so any grant bit in IDLE is a transfer.
    assign accept   = (state_q == IDLE) && (|arb_gnt);
    assign done_now = (state_q == BUSY) && bus.mul_done;

`ifdef MUL_ARB_TIMEOUT_EN
    localparam int CNTW = $clog2(TIMEOUT + 1);
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            err_q, err_d;

    // cnt_q holds the number of completed BUSY cycles, so TIMEOUT-1 marks
    // the last allowed one. A done in that same cycle takes precedence.
    assign timeout_now = (state_q == BUSY) && !bus.mul_done &&
                         (cnt_q == CNTW'(TIMEOUT - 1));

    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (accept)                    cnt_d = '0;
        else if (state_q == BUSY)      cnt_d = cnt_q + 1'b1;
        if (done_now)                  err_d = 1'b0;
        else if (timeout_now)          err_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign resp_err_w = err_q;
`else
    assign timeout_now = 1'b0;
    assign resp_err_w  = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = BUSY;
            BUSY:    if (done_now || timeout_now) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values: pointer, grant index, operands, result
    always_comb begin
        ptr_d   = ptr_q;
        grant_d = grant_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        if (accept) begin
            ptr_d   = arb_idx;
            grant_d = arb_idx;
            for (int i = 0; i < N_REQ; i++) begin
                if (arb_gnt[i]) begin
                    a_d = bus.req_a[i*XLEN +: XLEN];
                    b_d = bus.req_b[i*XLEN +: XLEN];
                end
            end
        end
        if (done_now)         res_d = bus.mul_res;
        else if (timeout_now) res_d = '0;
    end

    // Pointer resets to the last lane so requester 0 is searched first.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q   <= IDXW'(N_REQ - 1);
            grant_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
        end else begin
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
        end
    end

    // Output logic
    always_comb begin
        bus.req_ready  = '0;
        bus.resp_valid = '0;
        bus.resp_res   = '0;
        bus.resp_err   = 1'b0;
        bus.mul_start  = 1'b0;
        case (state_q)
            IDLE: bus.req_ready = arb_gnt;
            BUSY: bus.mul_start = 1'b1;
            RESP: begin
                bus.resp_valid[grant_q] = 1'b1;
                bus.resp_res            = res_q;
                bus.resp_err            = resp_err_w;
            end
            default: ;
        endcase
    end

    assign bus.mul_a = a_q;
    assign bus.mul_b = b_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_mul_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mul_arbiter
// Bench for mul_arbiter with three requesters and a behavioural multiplier
// whose latency (BUSY cycles until mul_done) is set by the bench.
// -----------------------------------------------------------------------------
module tb_mul_arbiter;
    import mul_arb_pkg::*;

    localparam int N   = 3;
    localparam int X   = 32;
    localparam int TMO = 40;

    // ---------------- clock / reset ----------------
    logic   clk = 1'b0;
    logic   rst = 1'b1;
    state_e dbg_state;

    always #5 clk = ~clk;

    mul_arbiter_if #(.N_REQ(N), .XLEN(X)) bus ();

    mul_arbiter #(.N_REQ(N), .XLEN(X), .TIMEOUT(TMO)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .state_o (dbg_state)
    );

    // ---------------- multiplier model ----------------
    int lat       = 1;
    bit stuck     = 1'b0;
    int start_cnt = 0;

    always @(posedge clk) begin
        if (rst || !bus.mul_start) start_cnt <= 0;
        else                       start_cnt <= start_cnt + 1;
    end

    assign bus.mul_done = bus.mul_start && !stuck && (start_cnt >= lat - 1);
    assign bus.mul_res  = bus.mul_done ? (bus.mul_a * bus.mul_b) : 32'hDEAD_BEEF;

    // ---------------- scoreboard / reference model ----------------
    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [X-1:0] exp_q[$];
    bit           m_busy = 1'b0;
    int           m_resp = 0;
    int           m_idx  = 0;
    int           m_ptr  = N - 1;
    bit           m_err  = 1'b0;
    logic [X-1:0] m_a, m_b;

    int           grant_log[$];
    int           grant_cyc_log[$];
    int           resp_idx_log[$];
    int           resp_cyc_log[$];
    logic [X-1:0] resp_res_log[$];
    logic         resp_err_log[$];
    int           start_cycles = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Round-robin rule: first valid lane after the last winner, wrapping.
    function automatic int rr_pick(input logic [N-1:0] v, input int ptr);
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (ptr + k) % N;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    task automatic clear_logs();
        grant_log.delete();
        grant_cyc_log.delete();
        resp_idx_log.delete();
        resp_cyc_log.delete();
        resp_res_log.delete();
        resp_err_log.delete();
        start_cycles = 0;
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        repeat (2) @(negedge clk);
        m_busy = 1'b0;
        m_ptr  = N - 1;
        exp_q.delete();
    endtask

    // One clock cycle: drive inputs, compare outputs against the model,
    // log what the DUT did, then advance the model.
    task automatic step(input bit r, input logic [N-1:0] v,
                        input logic [N*X-1:0] a, input logic [N*X-1:0] b);
        logic [N-1:0] exp_rdy;
        logic [N-1:0] exp_rv;
        logic [X-1:0] exp_res;
        logic [X-1:0] prod;
        bit           exp_err;
        bit           exp_start;
        bit           will_err;
        int           pick;
        int           eff;
        @(negedge clk);
        rst           = r;
        bus.req_valid = v;
        bus.req_a     = a;
        bus.req_b     = b;
        #1;
        cyc++;
        exp_rdy   = '0;
        exp_rv    = '0;
        exp_res   = '0;
        exp_err   = 1'b0;
        exp_start = 1'b0;
        pick      = -1;
        if (!m_busy) begin
            pick = rr_pick(v, m_ptr);
            if (pick >= 0) exp_rdy[pick] = 1'b1;
        end else if (cyc == m_resp) begin
            exp_rv[m_idx] = 1'b1;
            exp_res       = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hBAD0_BAD0;
            exp_err       = m_err;
        end else begin
            exp_start = 1'b1;
        end
        chk("req_ready", bus.req_ready, exp_rdy);
        chk("resp_valid", bus.resp_valid, exp_rv);
        chk("resp_res", bus.resp_res, exp_res);
        chk("resp_err", bus.resp_err, exp_err);
        chk("mul_start", bus.mul_start, exp_start);
        if (exp_start) begin
            chk("mul_a", bus.mul_a, m_a);
            chk("mul_b", bus.mul_b, m_b);
        end
        if (bus.mul_start) start_cycles++;
        for (int i = 0; i < N; i++) begin
            if (bus.req_ready[i] && v[i]) begin
                grant_log.push_back(i);
                grant_cyc_log.push_back(cyc);
            end
            if (bus.resp_valid[i]) begin
                resp_idx_log.push_back(i);
                resp_cyc_log.push_back(cyc);
                resp_res_log.push_back(bus.resp_res);
                resp_err_log.push_back(bus.resp_err);
            end
        end
        if (r) begin
            m_busy = 1'b0;
            m_ptr  = N - 1;
            exp_q.delete();
        end else if (m_busy && cyc == m_resp) begin
            m_busy = 1'b0;
        end else if (!m_busy && pick >= 0) begin
            m_busy = 1'b1;
            m_idx  = pick;
            m_ptr  = pick;
            m_a    = a[pick*X +: X];
            m_b    = b[pick*X +: X];
`ifdef MUL_ARB_TIMEOUT_EN
            will_err = stuck || (lat > TMO);
            eff      = will_err ? TMO : lat;
`else
            will_err = 1'b0;
            eff      = lat;
`endif
            m_err  = will_err;
            m_resp = cyc + eff + 1;
            prod   = m_a * m_b;
            exp_q.push_back(will_err ? '0 : prod);
        end
    endtask

    task automatic run_until_resp(input logic [N-1:0] v, input logic [N*X-1:0] a,
                                  input logic [N*X-1:0] b, input int want, input string name);
        int n;
        n = 0;
        while (resp_idx_log.size() < want && n < 300) begin
            step(1'b0, v, a, b);
            n++;
        end
        chk({name, "_resp_seen"}, resp_idx_log.size() >= want, 1'b1);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (m_busy && n < 300) begin
            step(1'b0, '0, '0, '0);
            n++;
        end
        chk({name, "_drained"}, m_busy, 1'b0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int           req;
        logic [X-1:0] a;
        logic [X-1:0] b;
        int           lat;
        logic [X-1:0] res;
    } vec_t;

    vec_t tbl[8];
    int   exp_g[4] = '{0, 1, 0, 1};
    int   exp_p[4] = '{12, 30, 12, 30};

    // Watchdog: stops a run that stalls somewhere unexpected.
    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0]   vv;
        logic [N*X-1:0] va, vb;
        logic [N-1:0]   pend;
        logic [N*X-1:0] ra, rb;
        int             n;

        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;

        tbl[0] = '{0, 32'd7,         32'hFFFF_FFFD, 5, 32'hFFFF_FFEB};
        tbl[1] = '{1, 32'd3,         32'd4,         2, 32'd12};
        tbl[2] = '{1, 32'd5,         32'd6,         3, 32'd30};
        tbl[3] = '{0, 32'd0,         32'h1234_5678, 1, 32'd0};
        tbl[4] = '{2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4, 32'd1};
        tbl[5] = '{0, 32'h0001_0000, 32'h0001_0000, 2, 32'd0};
        tbl[6] = '{1, 32'h1234_5678, 32'h10,        1, 32'h2345_6780};
        tbl[7] = '{2, 32'h8000_0001, 32'd3,         6, 32'h8000_0003};

        // ---- reset state ----
        do_reset();
        #1;
        chk("rst_req_ready", bus.req_ready, '0);
        chk("rst_resp_valid", bus.resp_valid, '0);
        chk("rst_resp_res", bus.resp_res, '0);
        chk("rst_resp_err", bus.resp_err, 1'b0);
        chk("rst_mul_start", bus.mul_start, 1'b0);
        chk("rst_mul_a", bus.mul_a, '0);
        chk("rst_mul_b", bus.mul_b, '0);
        chk("rst_state", dbg_state, IDLE);

        // ---- table: single operations with known products and latency ----
        for (int t = 0; t < 8; t++) begin
            lat = tbl[t].lat;
            clear_logs();
            va = '0;
            vb = '0;
            vv = '0;
            va[tbl[t].req*X +: X] = tbl[t].a;
            vb[tbl[t].req*X +: X] = tbl[t].b;
            vv[tbl[t].req]        = 1'b1;
            step(1'b0, vv, va, vb);
            run_until_resp('0, '0, '0, 1, $sformatf("tbl%0d", t));
            chk($sformatf("tbl%0d_grant", t), (grant_log.size() > 0) ? grant_log[0] : -1, tbl[t].req);
            chk($sformatf("tbl%0d_resp_idx", t), (resp_idx_log.size() > 0) ? resp_idx_log[0] : -1, tbl[t].req);
            chk($sformatf("tbl%0d_res", t), (resp_res_log.size() > 0) ? resp_res_log[0] : 32'hBAD0_BAD0, tbl[t].res);
            chk($sformatf("tbl%0d_latency", t),
                (resp_cyc_log.size() > 0 && grant_cyc_log.size() > 0) ? resp_cyc_log[0] - grant_cyc_log[0] : -1,
                tbl[t].lat + 1);
            chk($sformatf("tbl%0d_busy_cycles", t), start_cycles, tbl[t].lat);
        end

        // ---- contention: req0 and req1 valid continuously after reset ----
        do_reset();
        clear_logs();
        lat = 2;
        va = '0;
        vb = '0;
        va[0 +: X] = 32'd3;
        vb[0 +: X] = 32'd4;
        va[X +: X] = 32'd5;
        vb[X +: X] = 32'd6;
        run_until_resp(3'b011, va, vb, 4, "cont");
        for (int j = 0; j < 4; j++) begin
            chk($sformatf("cont_grant%0d", j), (grant_log.size() > j) ? grant_log[j] : -1, exp_g[j]);
            chk($sformatf("cont_resp_idx%0d", j), (resp_idx_log.size() > j) ? resp_idx_log[j] : -1, exp_g[j]);
            chk($sformatf("cont_res%0d", j), (resp_res_log.size() > j) ? resp_res_log[j] : 32'hBAD0_BAD0, exp_p[j]);
        end
        drain("cont");

        // ---- reset asserted on the third BUSY cycle ----
        do_reset();
        clear_logs();
        lat = 10;
        va = '0;
        vb = '0;
        va[0 +: X] = 32'd9;
        vb[0 +: X] = 32'd11;
        step(1'b0, 3'b001, va, vb);
        step(1'b0, '0, va, vb);
        step(1'b0, '0, va, vb);
        step(1'b1, '0, va, vb);
        step(1'b0, '0, va, vb);
        chk("rstb_start_low", bus.mul_start, 1'b0);
        chk("rstb_no_resp", resp_idx_log.size(), 0);
        chk("rstb_state_idle", dbg_state, IDLE);
        va[X +: X] = 32'd7;
        vb[X +: X] = 32'd8;
        step(1'b0, 3'b011, va, vb);
        chk("rstb_regrant_req0", bus.req_ready, 3'b001);
        drain("rstb");
        chk("rstb_res", (resp_res_log.size() > 0) ? resp_res_log[0] : 32'hBAD0_BAD0, 32'd99);

        // ---- late arrival during BUSY, then a withdrawn request ----
        clear_logs();
        lat = 4;
        va = '0;
        vb = '0;
        va[0 +: X] = 32'd21;
        vb[0 +: X] = 32'd2;
        va[X +: X] = 32'd13;
        vb[X +: X] = 32'd3;
        step(1'b0, 3'b001, va, vb);
        n = 0;
        while (!bus.req_ready[1] && n < 20) begin
            step(1'b0, 3'b010, va, vb);
            n++;
        end
        chk("late_ready_seen", bus.req_ready[1], 1'b1);
        chk("late_ready_cycle",
            (grant_cyc_log.size() > 1) ? grant_cyc_log[1] : -1,
            (resp_cyc_log.size() > 0) ? resp_cyc_log[0] + 1 : -2);
        step(1'b0, 3'b001, va, vb);
        step(1'b0, 3'b001, va, vb);
        drain("wd");
        repeat (3) step(1'b0, '0, va, vb);
        chk("wd_grants", grant_log.size(), 2);
        chk("wd_busy_cycles", start_cycles, 8);
        chk("wd_res0", (resp_res_log.size() > 0) ? resp_res_log[0] : 32'hBAD0_BAD0, 32'd42);
        chk("wd_res1", (resp_res_log.size() > 1) ? resp_res_log[1] : 32'hBAD0_BAD0, 32'd39);

`ifdef MUL_ARB_TIMEOUT_EN
        // ---- timeout with mul_done stuck low, then done on the last cycle ----
        clear_logs();
        stuck = 1'b1;
        va = '0;
        vb = '0;
        va[2*X +: X] = 32'd5;
        vb[2*X +: X] = 32'd5;
        step(1'b0, 3'b100, va, vb);
        run_until_resp('0, '0, '0, 1, "tmo");
        chk("tmo_latency", (resp_cyc_log.size() > 0) ? resp_cyc_log[0] - grant_cyc_log[0] : -1, TMO + 1);
        chk("tmo_err", (resp_err_log.size() > 0) ? resp_err_log[0] : 1'b0, 1'b1);
        chk("tmo_res", (resp_res_log.size() > 0) ? resp_res_log[0] : 32'hBAD0_BAD0, 32'd0);
        chk("tmo_busy_cycles", start_cycles, TMO);
        stuck = 1'b0;
        lat   = TMO;
        clear_logs();
        step(1'b0, 3'b100, va, vb);
        run_until_resp('0, '0, '0, 1, "tmo_done");
        chk("tmo_done_latency", (resp_cyc_log.size() > 0) ? resp_cyc_log[0] - grant_cyc_log[0] : -1, TMO + 1);
        chk("tmo_done_err", (resp_err_log.size() > 0) ? resp_err_log[0] : 1'b1, 1'b0);
        chk("tmo_done_res", (resp_res_log.size() > 0) ? resp_res_log[0] : 32'hBAD0_BAD0, 32'd25);
`else
        // ---- long operation: BUSY waits for mul_done with no abort ----
        clear_logs();
        lat = 60;
        va = '0;
        vb = '0;
        va[2*X +: X] = 32'd5;
        vb[2*X +: X] = 32'd5;
        step(1'b0, 3'b100, va, vb);
        run_until_resp('0, '0, '0, 1, "long");
        chk("long_latency", (resp_cyc_log.size() > 0) ? resp_cyc_log[0] - grant_cyc_log[0] : -1, 61);
        chk("long_err", (resp_err_log.size() > 0) ? resp_err_log[0] : 1'b1, 1'b0);
        chk("long_res", (resp_res_log.size() > 0) ? resp_res_log[0] : 32'hBAD0_BAD0, 32'd25);
`endif

        // ---- randomized traffic against the reference model ----
        for (int ph = 0; ph < 3; ph++) begin
            lat  = (ph == 0) ? 1 : ((ph == 1) ? 3 : 7);
            pend = '0;
            ra   = '0;
            rb   = '0;
            for (int s = 0; s < 150; s++) begin
                for (int i = 0; i < N; i++) begin
                    if (pend[i]) begin
                        if ($urandom_range(15) == 0) pend[i] = 1'b0;
                    end else if ($urandom_range(2) == 0) begin
                        pend[i]        = 1'b1;
                        ra[i*X +: X]   = ($urandom_range(7) == 0) ? 32'd0 : $urandom;
                        rb[i*X +: X]   = $urandom;
                    end
                end
                step(1'b0, pend, ra, rb);
                for (int i = 0; i < N; i++) begin
                    if (bus.req_ready[i]) pend[i] = 1'b0;
                end
            end
            drain($sformatf("rand%0d", ph));
        end

        // ---- final report ----
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
